// File: rtl/serial_subtractor_pkg.sv
// -----------------------------------------------------------------------------
// serial_subtractor_pkg
//   Shared definitions for the bit-serial subtractor.
//   - state_e     : controller states (IDLE, RUN, DONE)
//   - HACK_WORD_W : default operand width (one Hack machine word)
// -----------------------------------------------------------------------------
package serial_subtractor_pkg;

  localparam int HACK_WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : serial_subtractor_pkg

// File: rtl/full_subtractor.sv
// -----------------------------------------------------------------------------
// full_subtractor
//   One-bit full subtractor cell computing a - b - bin.
//   Ports:
//     a, b  : minuend / subtrahend bit
//     bin   : borrow in from the previous (less significant) bit
//     d     : difference bit
//     bout  : borrow out to the next (more significant) bit
// -----------------------------------------------------------------------------
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  // Borrow when b exceeds a outright, or when the bits are equal and a borrow
  // is already pending from below.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial two's-complement subtractor: diff = a - b (mod 2^WIDTH), one bit
//   per clock, LSB first, through a single full_subtractor cell.
//
//   Handshake: start is accepted in IDLE or DONE; busy is high for WIDTH cycles
//   while the bits are processed; done pulses for one cycle when the results
//   are updated. Results hold until the next operation completes.
//
//   Parameters:
//     WIDTH   : operand/result width, 2..32 (default HACK_WORD_W = 16)
//   Ports:
//     clk     : system clock, rising edge
//     reset_n : asynchronous active-low reset
//     start   : operation request, sampled only when busy = 0
//     a, b    : minuend / subtrahend, captured on an accepted start
//     busy    : operation in progress
//     done    : one-cycle pulse, results valid from this cycle on
//     diff    : a - b modulo 2^WIDTH
//     borrow  : unsigned borrow out (a < b as unsigned)
//     zr      : diff == 0
//     ng      : diff[WIDTH-1]
//     ovf     : signed overflow (only with SERIAL_SUBTRACTOR_OVF_EN defined)
//
//   Build option:
//     SERIAL_SUBTRACTOR_OVF_EN : adds the ovf output and the operand-MSB
//                                capture that feeds it.
// -----------------------------------------------------------------------------
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = HACK_WORD_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zr,
  output logic             ng
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int             CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e             state_q,  state_d;
  logic [WIDTH-1:0]   sa_q,     sa_d;      // minuend shift register
  logic [WIDTH-1:0]   sb_q,     sb_d;      // subtrahend shift register
  logic [WIDTH-1:0]   sr_q,     sr_d;      // result shift register
  logic               bin_q,    bin_d;     // borrow carried between bits
  logic [CNT_W-1:0]   count_q,  count_d;   // bit index being processed

  logic               busy_q,   busy_d;
  logic               done_q,   done_d;
  logic [WIDTH-1:0]   diff_q,   diff_d;
  logic               borrow_q, borrow_d;
  logic               zr_q,     zr_d;
  logic               ng_q,     ng_d;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic               a_msb_q,  a_msb_d;   // sign of the captured minuend
  logic               b_msb_q,  b_msb_d;   // sign of the captured subtrahend
  logic               ovf_q,    ovf_d;
`endif

  // ---------------------------------------------------------------------------
  // Datapath: the single subtractor cell and the result after this cycle's shift
  // ---------------------------------------------------------------------------
  logic               cell_d;
  logic               cell_bout;
  logic [WIDTH-1:0]   sr_shifted;

  full_subtractor u_cell (
    .a    (sa_q[0]),
    .b    (sb_q[0]),
    .bin  (bin_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // The difference bit enters at the MSB so that after WIDTH shifts the LSB
  // computed first has reached bit 0.
  assign sr_shifted = {cell_d, sr_q[WIDTH-1:1]};

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here first receives its held value, so no
    // path through the case leaves it unassigned and no latch is inferred.
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    sr_d     = sr_q;
    bin_d    = bin_q;
    count_d  = count_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    zr_d     = zr_q;
    ng_d     = ng_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    ovf_d    = ovf_q;
`endif

    unique case (state_q)
      // IDLE and DONE accept a new request identically; DONE lasts one cycle.
      IDLE, DONE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          bin_d   = 1'b0;
          count_d = '0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
`endif
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        sa_d    = sa_q >> 1;
        sb_d    = sb_q >> 1;
        sr_d    = sr_shifted;
        bin_d   = cell_bout;
        count_d = count_q + 1'b1;

        if (count_q == LAST_BIT) begin
          // Last bit: publish results on this edge. Result outputs change
          // nowhere else, so they stay stable through the next operation.
          count_d  = '0;
          diff_d   = sr_shifted;
          borrow_d = cell_bout;
          zr_d     = (sr_shifted == '0);
          ng_d     = cell_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
          // Overflow only when the operand signs differ and the result sign
          // does not follow the minuend.
          ovf_d    = (a_msb_q != b_msb_q) && (cell_d != a_msb_q);
`endif
          state_d  = DONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Handshake outputs are registered decodes of the next state.
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      sr_q     <= '0;
      bin_q    <= 1'b0;
      count_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      zr_q     <= 1'b0;
      ng_q     <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments make every register sample the values
      // from before this edge, independent of statement order.
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      sr_q     <= sr_d;
      bin_q    <= bin_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      zr_q     <= zr_d;
      ng_q     <= ng_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy   = busy_q;
  assign done   = done_q;
  assign diff   = diff_q;
  assign borrow = borrow_q;
  assign zr     = zr_q;
  assign ng     = ng_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  assign ovf    = ovf_q;
`endif

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//   Self-checking bench for serial_subtractor (WIDTH = 16). A transaction-level
//   model predicts busy/done timing and the arithmetic results from a - b;
//   one compare process checks every cycle, and directed cases pin literal
//   values. Honours SERIAL_SUBTRACTOR_OVF_EN for the ovf output.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_serial_subtractor;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done, borrow, zr, ng;
  logic [W-1:0] diff;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic         ovf;
`endif

  int total = 0;
  int bad   = 0;
  int done_seen = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .diff    (diff),
    .borrow  (borrow),
    .zr      (zr),
    .ng      (ng)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    .ovf     (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: an accepted request occupies W busy cycles, then one done
  // cycle; results are plain modular subtraction of the captured operands.
  // ---------------------------------------------------------------------------
  int           m_rem;
  logic         m_done;
  logic [W-1:0] m_diff, pa, pb;
  logic         m_borrow, m_zr, m_ng, m_ovf;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_rem    <= 0;
      m_done   <= 1'b0;
      m_diff   <= '0;
      m_borrow <= 1'b0;
      m_zr     <= 1'b0;
      m_ng     <= 1'b0;
      m_ovf    <= 1'b0;
      pa       <= '0;
      pb       <= '0;
    end else if (m_rem > 0) begin
      m_rem <= m_rem - 1;
      if (m_rem == 1) begin
        logic [W-1:0] r;
        r = pa - pb;
        m_done   <= 1'b1;
        m_diff   <= r;
        m_borrow <= (pa < pb);
        m_zr     <= (r == '0);
        m_ng     <= r[W-1];
        m_ovf    <= (pa[W-1] != pb[W-1]) && (r[W-1] != pa[W-1]);
      end
    end else begin
      m_done <= 1'b0;
      if (start) begin
        m_rem <= W;
        pa    <= a;
        pb    <= b;
      end
    end
  end

  // Single compare process: outputs are meaningful in every out-of-reset cycle.
  always @(negedge clk) begin
    if (reset_n) begin
      check("busy",   busy,   m_rem > 0);
      check("done",   done,   m_done);
      check("diff",   diff,   m_diff);
      check("borrow", borrow, m_borrow);
      check("zr",     zr,     m_zr);
      check("ng",     ng,     m_ng);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      check("ovf",    ovf,    m_ovf);
`endif
      if (done) done_seen++;
    end
  end

  // ---------------------------------------------------------------------------
  // Drivers
  // ---------------------------------------------------------------------------
  // Called with start already driven for the coming edge. Returns the number of
  // rising edges up to the done cycle and the number of busy cycles seen.
  // A one-cycle start pulse with (ia, ib) is injected after edge inj (0 = none).
  task automatic wait_done(input int inj, input logic [W-1:0] ia, input logic [W-1:0] ib,
                           output int edges, output int bcnt);
    bit found;
    found = 1'b0;
    bcnt  = 0;
    @(posedge clk);
    edges = 1;
    #1;
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (done) begin
        found = 1'b1;
      end else begin
        if (busy) bcnt++;
        @(posedge clk);
        edges++;
        #1;
        if (edges == inj) begin
          start = 1'b1;
          a = ia;
          b = ib;
        end else begin
          start = 1'b0;
        end
      end
    end
    if (!found) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b, input int inj,
                       input logic [W-1:0] ia, input logic [W-1:0] ib,
                       output int edges, output int bcnt);
    @(posedge clk);
    #1;
    start = 1'b1;
    a = op_a;
    b = op_b;
    wait_done(inj, ia, ib, edges, bcnt);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges, bcnt;
    logic [W-1:0] ra, rb;

    reset_n = 1'b0;
    start   = 1'b0;
    a       = '0;
    b       = '0;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_diff", diff, '0);
    check("rst_flags", {borrow, zr, ng}, 3'b000);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // 5 - 3
    do_op(16'd5, 16'd3, 0, '0, '0, edges, bcnt);
    check("lat_5m3", edges, W + 1);
    check("busy_5m3", bcnt, W);
    check("diff_5m3", diff, 16'h0002);
    check("flags_5m3", {borrow, zr, ng}, 3'b000);

    // 3 - 5
    do_op(16'd3, 16'd5, 0, '0, '0, edges, bcnt);
    check("diff_3m5", diff, 16'hFFFE);
    check("flags_3m5", {borrow, zr, ng}, 3'b101);

    // equal operands
    do_op(16'h1234, 16'h1234, 0, '0, '0, edges, bcnt);
    check("diff_eq", diff, 16'h0000);
    check("flags_eq", {borrow, zr, ng}, 3'b010);

    // most negative minus one
    do_op(16'h8000, 16'h0001, 0, '0, '0, edges, bcnt);
    check("diff_min", diff, 16'h7FFF);
    check("flags_min", {borrow, zr, ng}, 3'b000);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    check("ovf_min", ovf, 1'b1);
    do_op(16'd2, 16'd1, 0, '0, '0, edges, bcnt);
    check("ovf_2m1", ovf, 1'b0);
    check("diff_2m1", diff, 16'h0001);
`endif

    // start pulse during an active op is ignored
    do_op(16'd5, 16'd3, 5, 16'd9, 16'd4, edges, bcnt);
    check("lat_ignored", edges, W + 1);
    check("diff_ignored", diff, 16'h0002);

    // start held in the DONE cycle: next op starts at once
    start = 1'b1;
    a = 16'd7;
    b = 16'd10;
    wait_done(0, '0, '0, edges, bcnt);
    check("b2b_interval", edges, W + 1);
    check("b2b_busy", bcnt, W);
    check("diff_b2b", diff, 16'hFFFD);
    check("borrow_b2b", borrow, 1'b1);

    // reset during RUN
    @(posedge clk);
    #1;
    start = 1'b1;
    a = 16'd5;
    b = 16'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    check("busy_before_rst", busy, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_diff", diff, '0);
    check("midrst_flags", {borrow, zr, ng}, 3'b000);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    done_seen = 0;
    repeat (25) @(negedge clk);
    check("no_done_after_rst", done_seen, 0);
    do_op(16'd5, 16'd3, 0, '0, '0, edges, bcnt);
    check("diff_after_rst", diff, 16'h0002);
    check("lat_after_rst", edges, W + 1);

    // randomized operations, with occasional ignored starts and back-to-back
    for (int n = 0; n < 40; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (n % 10 == 0) rb = ra;
      if (n % 10 == 1) rb = 16'hFFFF;
      if (n % 10 == 2) ra = '0;
      if ((n % 4) == 3) begin
        start = 1'b1;
        a = ra;
        b = rb;
        wait_done(0, '0, '0, edges, bcnt);
      end else begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        do_op(ra, rb, ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 14)) : 0,
              W'($urandom), W'($urandom), edges, bcnt);
      end
      check("rand_lat", edges, W + 1);
      check("rand_busy", bcnt, W);
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_serial_subtractor
